// File: rtl/addsub_issue_unit_if.sv
// -----------------------------------------------------------------------------
// addsub_issue_unit_if
// Bundles the request, slice and result buses of addsub_issue_unit.
//   in_*    : request channel (valid/ready), upstream -> unit
//   slice_* : registered operands out to the adder/subtractor slice, and its
//             combinational sum/cout back in
//   out_*   : result channel (valid/ready), unit -> downstream
// Modports:
//   slave  : the issue unit itself
//   master : the environment (request source, slice, result consumer)
// -----------------------------------------------------------------------------
interface addsub_issue_unit_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;

    logic [W-1:0] slice_a;
    logic [W-1:0] slice_b;
    logic         slice_cin;
    logic [W-1:0] slice_sum;
    logic         slice_cout;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
        output in_ready,
        output slice_a, slice_b, slice_cin,
        input  slice_sum, slice_cout,
        output out_valid, out_sum, out_cout, out_zero,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_cin,
        input  in_ready,
        input  slice_a, slice_b, slice_cin,
        output slice_sum, slice_cout,
        input  out_valid, out_sum, out_cout, out_zero,
        output out_ready
    );
endinterface

// File: rtl/addsub_issue_unit.sv
// -----------------------------------------------------------------------------
// addsub_issue_unit
// Operand-issue / result-capture stage around a combinational add/sub slice.
//   S0: DEPTH-entry request FIFO {a, b, cin}
//   S1: issue registers driving the slice (slice_a/b/cin) + s1_valid
//   S2: result registers (out_sum/out_cout/out_zero) + out_valid
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : slave side of addsub_issue_unit_if (request, slice, result)
//   count : FIFO occupancy (S0 only)
//   busy  : any request queued or in flight
// -----------------------------------------------------------------------------
module addsub_issue_unit #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    addsub_issue_unit_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } req_t;

    req_t          mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          s1_valid;

    logic push;
    logic pop;
    logic s2_load;

    // Full means no accept, even if the head leaves this cycle.
    assign bus.in_ready = (count != FULL);
    assign push         = bus.in_valid & bus.in_ready;
    // S1 advances exactly when S2 can take its result.
    assign s2_load      = s1_valid & (~bus.out_valid | bus.out_ready);
    assign pop          = (count != '0) & (~s1_valid | s2_load);
    assign busy         = (count != '0) | s1_valid | bus.out_valid;

    // Storage carries no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{a: bus.in_a, b: bus.in_b, cin: bus.in_cin};
        end
    end

    // S0 pointers and occupancy; DEPTH is a power of 2 so pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // S1: operands hold their last value when S1 empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.slice_a   <= '0;
            bus.slice_b   <= '0;
            bus.slice_cin <= 1'b0;
            s1_valid      <= 1'b0;
        end else if (pop) begin
            bus.slice_a   <= mem[head].a;
            bus.slice_b   <= mem[head].b;
            bus.slice_cin <= mem[head].cin;
            s1_valid      <= 1'b1;
        end else if (s2_load) begin
            s1_valid      <= 1'b0;
        end
    end

    // S2: result registers; held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= bus.slice_sum;
            bus.out_cout  <= bus.slice_cout;
            bus.out_zero  <= (bus.slice_sum == '0);
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_addsub_issue_unit
// Drives addsub_issue_unit with directed and randomized requests, models the
// slice combinationally, and compares every delivered result with a
// request-order queue of results computed from plain add/subtract arithmetic.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_addsub_issue_unit;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] count;
    logic          busy;

    always #5 clk = ~clk;

    addsub_issue_unit_if #(.W(W)) bus ();

    addsub_issue_unit #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .busy  (busy)
    );

    // Slice: sum = a + (b ^ {W{cin}}) + cin, cout = carry out.
    assign {bus.slice_cout, bus.slice_sum} =
        {1'b0, bus.slice_a} + {1'b0, (bus.slice_b ^ {W{bus.slice_cin}})} +
        {{W{1'b0}}, bus.slice_cin};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accepted = 0;

    logic [W+1:0] exp_q [$];   // {zero, cout, sum} in request order
    logic [W+1:0] got_q [$];
    int           got_cyc [$];

    // Expected result from ordinary arithmetic: cin=1 is a - b with
    // carry meaning "no borrow", cin=0 is a + b with carry meaning overflow.
    function automatic logic [W+1:0] exp_res(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic cin);
        int           r;
        logic         c;
        logic [W-1:0] s;
        if (cin) begin
            r = int'(a) - int'(b);
            c = (a >= b);
        end else begin
            r = int'(a) + int'(b);
            c = (r >= (1 << W));
        end
        s = r[W-1:0];
        return {(s == '0), c, s};
    endfunction

    // One clock: log the transfers about to happen at the rising edge,
    // then return on the next falling edge.
    task automatic tick();
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(exp_res(bus.in_a, bus.in_b, bus.in_cin));
            accepted++;
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back({bus.out_zero, bus.out_cout, bus.out_sum});
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) tick();
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        accepted = 0;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, count, busy} !== {1'b1, CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_hs: got ready/count/busy %b/%0d/%b want 1/0/0",
                     bus.in_ready, count, busy);
        end
        checks++;
        if ({bus.slice_a, bus.slice_b, bus.slice_cin} !== '0) begin
            failures++;
            $display("FAIL reset_slice: got %h/%h/%b want 0/0/0",
                     bus.slice_a, bus.slice_b, bus.slice_cin);
        end
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_zero} !== '0) begin
            failures++;
            $display("FAIL reset_out: got v/sum/c/z %b/%h/%b/%b want 0/0/0/0",
                     bus.out_valid, bus.out_sum, bus.out_cout, bus.out_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        clear_model();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd5, 4'd7, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (count !== CW'(1) || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_edge1: got count=%0d valid=%b want 1/0", count, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || count !== CW'(0)) begin
            failures++;
            $display("FAIL single_edge2: got valid=%b count=%0d want 0/0", bus.out_valid, count);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 ||
            {bus.out_zero, bus.out_cout, bus.out_sum} !== {1'b0, 1'b0, 4'd12}) begin
            failures++;
            $display("FAIL single_result: got v=%b z/c/sum=%b/%b/%0d want 1 0/0/12",
                     bus.out_valid, bus.out_zero, bus.out_cout, bus.out_sum);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || got_q.size() != 1) begin
            failures++;
            $display("FAIL single_drain: got busy=%b results=%0d want 0/1", busy, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] want [3];
        want[0] = {1'b0, 1'b0, 4'd15};
        want[1] = {1'b0, 1'b0, 4'd11};
        want[2] = {1'b0, 1'b1, 4'd9};
        clear_model();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd1, 4'd2, 1'b1);  tick();
        drive(1'b1, 4'd10, 4'd1, 1'b0); tick();
        drive(1'b1, 4'd10, 4'd1, 1'b1); tick();
        drive(1'b0, '0, '0, 1'b0);
        run_until(3, 12);
        checks++;
        if (got_q.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d results want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    failures++;
                    $display("FAIL b2b_result%0d: got %b want %b", i, got_q[i], want[i]);
                end
            end
            checks++;
            if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
                failures++;
                $display("FAIL b2b_spacing: got cycles %0d,%0d,%0d want consecutive",
                         got_cyc[0], got_cyc[1], got_cyc[2]);
            end
        end
    endtask

    task automatic test_zero();
        clear_model();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd3, 4'd3, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        run_until(1, 10);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL zero_flag: got n=%0d z/c/sum=%b want 1 result 1/1/0000",
                     got_q.size(), (got_q.size() != 0) ? got_q[0] : 'x);
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] held;
        bit           have;
        have = 1'b0;
        held = '0;
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            tick();
            if (bus.out_valid) begin
                if (have) begin
                    checks++;
                    if ({bus.out_zero, bus.out_cout, bus.out_sum} !== held) begin
                        failures++;
                        $display("FAIL bp_stable: got %b want %b",
                                 {bus.out_zero, bus.out_cout, bus.out_sum}, held);
                    end
                end else begin
                    held = {bus.out_zero, bus.out_cout, bus.out_sum};
                    have = 1'b1;
                end
            end
        end
        checks++;
        if (accepted != DEPTH + 2) begin
            failures++;
            $display("FAIL bp_accepted: got %0d want %0d", accepted, DEPTH + 2);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL bp_full: got ready=%b count=%0d want 0/%0d", bus.in_ready, count, DEPTH);
        end
        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        run_until(DEPTH + 2, 20);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || (i > 0 && got_cyc[i] != got_cyc[i-1] + 1)) begin
                    failures++;
                    $display("FAIL bp_result%0d: got %b @%0d want %b back-to-back",
                             i, got_q[i], got_cyc[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_simul();
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            tick();
        end
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL simul_setup: got count=%0d want 3", count);
        end
        drive_rand(1'b1);
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL simul_count: got count=%0d want 3", count);
        end
        drive(1'b0, '0, '0, 1'b0);
        run_until(6, 20);
        checks++;
        if (got_q.size() != 6 || got_q != exp_q) begin
            failures++;
            $display("FAIL simul_order: got %0d results (order ok=%b) want 6 in order",
                     got_q.size(), got_q == exp_q);
        end
    endtask

    task automatic test_wrap();
        clear_model();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        run_until(10, 20);
        checks++;
        if (got_q.size() != 10) begin
            failures++;
            $display("FAIL wrap_count: got %0d results want 10", got_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL wrap_result%0d: got %b want %b", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W+1:0] held;
        bit           stall;
        int           bad;
        bad = 0;
        clear_model();
        for (int i = 0; i < 300; i++) begin
            drive_rand(1'($urandom_range(0, 1)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            stall = bus.out_valid && !bus.out_ready;
            held  = {bus.out_zero, bus.out_cout, bus.out_sum};
            tick();
            checks++;
            if (stall && (bus.out_valid !== 1'b1 ||
                          {bus.out_zero, bus.out_cout, bus.out_sum} !== held)) begin
                failures++;
                $display("FAIL rand_stall@%0d: got v=%b %b want 1 %b", cyc, bus.out_valid,
                         {bus.out_zero, bus.out_cout, bus.out_sum}, held);
            end
            checks++;
            if (busy !== (accepted != got_q.size()) ||
                accepted - got_q.size() > DEPTH + 2) begin
                failures++;
                $display("FAIL rand_busy@%0d: got busy=%b inflight=%0d", cyc, busy,
                         accepted - got_q.size());
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        run_until(accepted, 30);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand_order: got %0d wrong results want 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || count !== CW'(0) || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear: got v=%b count=%0d ready=%b busy=%b want 0/0/1/0",
                     bus.out_valid, count, bus.in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {1'b0, 1'b0, 4'd4}) begin
            failures++;
            $display("FAIL rstmid_result: got n=%0d first=%b want 1 result 0/0/0100",
                     got_q.size(), (got_q.size() != 0) ? got_q[0] : 'x);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero();
        test_backpressure();
        test_simul();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/addsub_issue_unit.md
# addsub_issue_unit

Operand-issue and result-capture stage wrapped around the combinational `addersubtractor` slice. Accepts add/sub requests `{a, b, cin}` on a valid/ready input, buffers them in a DEPTH-entry FIFO, and drives them one per cycle into the slice through registered operand outputs. It captures the slice's `sum`/`cout` into a registered result presented on a valid/ready output. The datapath sits between the request source (upstream) and the result consumer (downstream), with the slice in the middle.

## Interface
- `W`, 4, operand/sum width; must match the slice.
- `DEPTH`, 4, request FIFO entries; power of 2, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  FIFO can accept; equals `count != DEPTH`.
- `in_a`, `in_b`  in  W  operands.
- `in_cin`  in  1  carry-in/mode bit, passed to the slice unmodified.
- `slice_a`, `slice_b`  out  W  registered operands to the slice `a`/`b`.
- `slice_cin`  out  1  registered to the slice `cin`.
- `slice_sum`  in  W  from the slice `sum`, combinational from `slice_*`.
- `slice_cout`  in  1  from the slice `cout`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_sum`  out  W  captured sum.
- `out_cout`  out  1  captured carry.
- `out_zero`  out  1  registered; 1 iff captured sum == 0.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy only.
- `busy`  out  1  `count != 0 | s1_valid | out_valid`.

## Operation
- Three stages:
  - S0: FIFO with head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - S1: issue registers `slice_*` plus internal `s1_valid`.
  - S2: output registers.
- Push: `in_valid & in_ready`. Writes `{in_a, in_b, in_cin}` at the tail pointer.
- S2 load: `s1_valid & (!out_valid | out_ready)`.
  - Captures `slice_sum`, `slice_cout` and `out_zero = (slice_sum == 0)`.
  - Sets `out_valid`.
- S2 drain: `out_valid & out_ready` with no S2 load clears `out_valid`.
- S1 advance: S2 load condition.
- Pop: `count != 0 & (!s1_valid | S1 advance)`.
  - Loads the head entry into `slice_a/b/cin`, sets `s1_valid`, increments the head pointer.
- If S1 advances with no pop, `s1_valid` clears. `slice_*` hold their last values.
- `count` next value:
  - `+1` on push only.
  - `−1` on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever `count < DEPTH`.
- Full: `in_ready = 0`. No pass-through at full, even if a pop occurs in the same cycle.
- Empty FIFO: no pop. S1 may still drain into S2.
- Ordering: results leave strictly in request order. No drops or duplicates under any `out_ready` pattern.
- Total buffering: DEPTH + 2 requests (FIFO + S1 + S2).
- `out_sum`, `out_cout` and `out_zero` are stable while `out_valid & !out_ready`.
- `in_*` are sampled only on a push. `slice_sum` is sampled only on an S2 load.

## Timing
- Reset (async assert, state cleared immediately):
  - `in_ready = 1`, `count = 0`, `busy = 0`.
  - `slice_a = slice_b = 0`, `slice_cin = 0`.
  - `out_valid = 0`, `out_sum = 0`, `out_cout = 0`, `out_zero = 0`.
  - Pointers = 0, `s1_valid = 0`.
- Reset mid-operation: all queued and in-flight requests are discarded. The first post-reset push behaves as from an empty pipeline.
- Latency, empty pipeline with `out_ready = 1`:
  - Push at edge k.
  - Pop into S1 at edge k+1.
  - `out_valid = 1` after edge k+2.
- Throughput: 1 result per cycle sustained while `out_ready = 1`.
- The slice path has a full cycle: `slice_*` register → slice → S2 register.

## Test plan
- Slice model in the bench: `sum = a + (b ^ {W{cin}}) + cin`, `cout` = carry.
- Single ops, each on an empty pipeline:
  - (5, 7, 0) → `out_sum = 12`, `cout = 0`, `zero = 0`.
  - `out_valid` rises 2 cycles after the push.
- Back-to-back pushes of (1,2,1), (10,1,0), (10,1,1), `out_ready = 1`:
  - Results on 3 consecutive cycles: 15/0, 11/0, 9/1.
- Zero flag: (3, 3, 1) → `out_sum = 0`, `cout = 1`, `out_zero = 1`.
- Backpressure, `out_ready = 0` while pushing continuously:
  - Exactly 6 requests accepted (DEPTH 4 + 2).
  - `in_ready` low with `count = 4`.
  - `out_*` stable throughout.
  - Then `out_ready = 1` → all 6 results in order, 1 per cycle. `busy` falls after the last.
- Simultaneous push and pop at `count = 3` → `count` stays 3.
- Pointer wrap: over 10 ops, every result matches its request.
- Reset mid-stream: assert `rst` with 3 queued.
  - Immediately: `out_valid = 0`, `count = 0`, `in_ready = 1`.
  - Next push of (2, 2, 0) → single result 4.
